// File: rtl/chameleon96_pkg.sv
// chameleon96_pkg: shared state encoding, parameter defaults and helpers for the
// Chameleon96 HPS-to-SoC reset sequencer.
`default_nettype none

package chameleon96_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_STRETCH = 3'd1,
    ST_RUN     = 3'd2,
    ST_WREQ    = 3'd3,
    ST_WWAIT   = 3'd4
  } state_t;

  localparam int DEF_SYNC_STAGES     = 2;
  localparam int DEF_STRETCH_CYCLES  = 16;
  localparam int DEF_WARM_REQ_CYCLES = 8;
  localparam int DEF_WARM_TIMEOUT    = 1024;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/chameleon96_sync.sv
// chameleon96_sync: single-bit multi-flop synchronizer with a selectable
// synchronous reset value.
`default_nettype none

module chameleon96_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic rst_val,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) begin
      ff <= {STAGES{rst_val}};
    end else begin
      ff <= {ff[STAGES-2:0], d};
    end
  end

  assign q = ff[STAGES-1];

endmodule

`default_nettype wire

// File: rtl/chameleon96_rst_seq.sv
// chameleon96_rst_seq: HPS reset synchronizer/stretcher producing the SERV SoC reset.
// Define CHAMELEON96_RSTSEQ_WARM_EN to add the f2h warm-reset request with timeout fallback.
`default_nettype none

module chameleon96_rst_seq
  import chameleon96_pkg::*;
#(
  parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
  parameter int STRETCH_CYCLES  = DEF_STRETCH_CYCLES,
  parameter int WARM_REQ_CYCLES = DEF_WARM_REQ_CYCLES,
  parameter int WARM_TIMEOUT    = DEF_WARM_TIMEOUT
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_hps_rst_n,
  input  logic i_sw_rst_req,
  output logic o_rst,
  output logic o_running,
  output logic o_f2h_warm_rst_req_n,
  output logic o_warm_timeout
);

  localparam int CNT_W = $clog2(max3(STRETCH_CYCLES, WARM_REQ_CYCLES, WARM_TIMEOUT)) + 1;
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
`ifdef CHAMELEON96_RSTSEQ_WARM_EN
  localparam logic [CNT_W-1:0] WREQ_LAST    = CNT_W'(WARM_REQ_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(WARM_TIMEOUT - 1);
`endif

  logic             hps_ok;
  state_t           state;
  state_t           next_state;
  logic [CNT_W-1:0] count;
  logic             timeout_hit;

  chameleon96_sync #(
    .STAGES (SYNC_STAGES)
  ) u_hps_sync (
    .clk     (i_clk),
    .rst     (i_rst),
    .rst_val (1'b0),
    .d       (i_hps_rst_n),
    .q       (hps_ok)
  );

  // Loss of the HPS reset release wins over every other transition.
  always_comb begin
    next_state  = state;
    timeout_hit = 1'b0;
    if (!hps_ok) begin
      next_state = ST_HOLD;
    end else begin
      case (state)
        ST_HOLD:    next_state = ST_STRETCH;
        ST_STRETCH: if (count == STRETCH_LAST) next_state = ST_RUN;
`ifdef CHAMELEON96_RSTSEQ_WARM_EN
        ST_RUN:     if (i_sw_rst_req) next_state = ST_WREQ;
        ST_WREQ:    if (count == WREQ_LAST) next_state = ST_WWAIT;
        ST_WWAIT: begin
          if (count == TIMEOUT_LAST) begin
            next_state  = ST_STRETCH;
            timeout_hit = 1'b1;
          end
        end
`else
        ST_RUN:     if (i_sw_rst_req) next_state = ST_STRETCH;
`endif
        default:    next_state = ST_HOLD;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= ST_HOLD;
      count     <= '0;
      o_rst     <= 1'b1;
      o_running <= 1'b0;
`ifdef CHAMELEON96_RSTSEQ_WARM_EN
      o_f2h_warm_rst_req_n <= 1'b1;
      o_warm_timeout       <= 1'b0;
`endif
    end else begin
      state <= next_state;
      if (next_state != state || next_state == ST_HOLD || next_state == ST_RUN) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
      o_rst     <= (next_state != ST_RUN);
      o_running <= (next_state == ST_RUN);
`ifdef CHAMELEON96_RSTSEQ_WARM_EN
      o_f2h_warm_rst_req_n <= (next_state != ST_WREQ);
      if (timeout_hit) o_warm_timeout <= 1'b1;
`endif
    end
  end

`ifndef CHAMELEON96_RSTSEQ_WARM_EN
  assign o_f2h_warm_rst_req_n = 1'b1;
  assign o_warm_timeout       = 1'b0;
`endif

endmodule

`default_nettype wire
